preg_alloc_ctrl: RTL and testbench

PREG_ALLOC_CTRL -- requirements
Module: preg_alloc_ctrl

---
 rtl/preg_alloc_pkg.sv | 15 +
 rtl/release_fifo.sv | 96 +++++++++
 rtl/preg_alloc_ctrl.sv | 123 ++++++++++++
 tb/tb_preg_alloc_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/preg_alloc_pkg.sv
// Shared definitions for the physical-register allocation controller.
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 5
`endif

package preg_alloc_pkg;
    localparam int NUM_ALLOC = 2;
    localparam int REL_DEPTH = 4;
    localparam int PR_W      = `PHYS_REG_IDX_SZ + 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/release_fifo.sv
// Release FIFO: two ordered push ports (slot 0 first), one pop port.
// Occupancy counter drives full/ready. Pushes beyond capacity are dropped
// and latch the sticky overflow flag.
module release_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        i_push_en,
    input  logic [1:0][W-1:0] i_push_pr,
    input  logic              i_pop,
    output logic [W-1:0]      o_head,
    output logic              o_empty,
    output logic              o_ready,
    output logic              o_overflow
);
    import preg_alloc_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic [CNT_W-1:0] w_space;
    logic             w_v0;
    logic             w_v1;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_drop;
    logic             w_pop;
    logic [1:0]       w_n_push;
    logic [PTR_W-1:0] w_wr_ptr1;

    // Pointer advance with explicit wrap, valid for any DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input logic [1:0] n);
        logic [PTR_W+1:0] s;
        s = {2'b00, p} + {{PTR_W{1'b0}}, n};
        if (s >= (PTR_W+2)'(DEPTH)) begin
            s = s - (PTR_W+2)'(DEPTH);
        end else begin
            s = s;
        end
        return s[PTR_W-1:0];
    endfunction

    // Push acceptance: zero registers are ignored, slot 0 takes space first.
    always_comb begin
        w_space   = CNT_W'(DEPTH) - r_count;
        w_v0      = i_push_en[0] & (i_push_pr[0] != {W{1'b0}});
        w_v1      = i_push_en[1] & (i_push_pr[1] != {W{1'b0}});
        w_acc0    = w_v0 & (w_space >= CNT_W'(1));
        w_acc1    = w_v1 & (w_space >= (w_acc0 ? CNT_W'(2) : CNT_W'(1)));
        w_drop    = (w_v0 & ~w_acc0) | (w_v1 & ~w_acc1);
        w_pop     = i_pop & (r_count != {CNT_W{1'b0}});
        w_n_push  = {1'b0, w_acc0} + {1'b0, w_acc1};
        w_wr_ptr1 = ptr_inc(r_wr_ptr, {1'b0, w_acc0});
    end

    // Storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_acc0) begin
                r_mem[r_wr_ptr] <= i_push_pr[0];
            end
            if (w_acc1) begin
                r_mem[w_wr_ptr1] <= i_push_pr[1];
            end
            r_wr_ptr <= ptr_inc(r_wr_ptr, w_n_push);
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr, 2'd1);
            end
            r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == {CNT_W{1'b0}});
    assign o_ready    = (w_space >= CNT_W'(2));
    assign o_overflow = r_overflow;
endmodule

// File: rtl/preg_alloc_ctrl.sv
// Physical-register allocation controller: two-entry prefetch buffer fed
// from the free list, in-order per-slot grants, and a release FIFO that
// drains retired registers back into the free list.
module preg_alloc_ctrl #(
    parameter int NUM_ALLOC = preg_alloc_pkg::NUM_ALLOC,
    parameter int REL_DEPTH = preg_alloc_pkg::REL_DEPTH
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_ALLOC-1:0]                      alloc_req,
    output logic [NUM_ALLOC-1:0]                      alloc_gnt,
    output logic [NUM_ALLOC-1:0][`PHYS_REG_IDX_SZ:0]  alloc_pr,
    input  logic [NUM_ALLOC-1:0]                      release_en,
    input  logic [NUM_ALLOC-1:0][`PHYS_REG_IDX_SZ:0]  release_pr,
    output logic                                      release_ready,
    output logic                                      release_overflow,
    input  logic                                      fl_is_empty,
    input  logic [`PHYS_REG_IDX_SZ:0]                 fl_dequeue_pr,
    output logic                                      fl_dequeue_en,
    output logic                                      fl_enqueue_en,
    output logic [`PHYS_REG_IDX_SZ:0]                 fl_enqueue_pr,
    output logic [1:0]                                prefetch_cnt
);
    import preg_alloc_pkg::*;

    state_t          r_state;
    logic [PR_W-1:0] r_pf [2];
    logic [1:0]      r_pf_cnt;

    logic            w_run;
    logic            w_gnt0;
    logic            w_gnt1;
    logic [1:0]      w_avail1;
    logic [1:0]      w_n_gnt;
    logic [1:0]      w_remain;
    logic            w_deq;
    logic [PR_W-1:0] w_nxt0;
    logic [PR_W-1:0] w_nxt1;
    logic [PR_W-1:0] w_fifo_head;
    logic            w_fifo_empty;
    logic            w_enq;

    // In-order grants from the prefetch buffer and free-list refill request.
    always_comb begin
        w_run    = (r_state == RUN);
        w_gnt0   = w_run & alloc_req[0] & (r_pf_cnt >= 2'd1);
        w_avail1 = r_pf_cnt - {1'b0, w_gnt0};
        w_gnt1   = w_run & alloc_req[1] & (~alloc_req[0] | w_gnt0) & (w_avail1 >= 2'd1);
        w_n_gnt  = {1'b0, w_gnt0} + {1'b0, w_gnt1};
        w_remain = r_pf_cnt - w_n_gnt;
        // A zero head is never a real register, so it is not consumed.
        w_deq    = w_run & ~fl_is_empty & (fl_dequeue_pr != {PR_W{1'b0}}) & (w_remain < 2'd2);
    end

    // Next buffer contents: survivors shift to the front, refill at the tail.
    always_comb begin
        case (w_n_gnt)
            2'd0: begin
                w_nxt0 = r_pf[0];
                w_nxt1 = r_pf[1];
            end
            2'd1: begin
                w_nxt0 = r_pf[1];
                w_nxt1 = {PR_W{1'b0}};
            end
            default: begin
                w_nxt0 = {PR_W{1'b0}};
                w_nxt1 = {PR_W{1'b0}};
            end
        endcase
        if (w_deq && (w_remain == 2'd0)) begin
            w_nxt0 = fl_dequeue_pr;
        end else if (w_deq) begin
            w_nxt1 = fl_dequeue_pr;
        end else begin
            w_nxt1 = w_nxt1;
        end
    end

    // State machine (INIT for one cycle, then RUN) and prefetch buffer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= INIT;
            r_pf[0]  <= {PR_W{1'b0}};
            r_pf[1]  <= {PR_W{1'b0}};
            r_pf_cnt <= 2'd0;
        end else begin
            case (r_state)
                INIT:    r_state <= RUN;
                RUN:     r_state <= RUN;
                default: r_state <= INIT;
            endcase
            r_pf[0]  <= w_nxt0;
            r_pf[1]  <= w_nxt1;
            r_pf_cnt <= w_remain + {1'b0, w_deq};
        end
    end

    assign w_enq = w_run & ~w_fifo_empty;

    release_fifo #(
        .DEPTH (REL_DEPTH),
        .W     (PR_W)
    ) u_release_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push_en  (release_en[1:0]),
        .i_push_pr  (release_pr[1:0]),
        .i_pop      (w_enq),
        .o_head     (w_fifo_head),
        .o_empty    (w_fifo_empty),
        .o_ready    (release_ready),
        .o_overflow (release_overflow)
    );

    assign alloc_gnt     = {w_gnt1, w_gnt0};
    assign alloc_pr[0]   = w_gnt0 ? r_pf[0] : {PR_W{1'b0}};
    assign alloc_pr[1]   = w_gnt1 ? (w_gnt0 ? r_pf[1] : r_pf[0]) : {PR_W{1'b0}};
    assign fl_dequeue_en = w_deq;
    assign fl_enqueue_en = w_enq;
    assign fl_enqueue_pr = w_fifo_head;
    assign prefetch_cnt  = r_pf_cnt;
endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Directed bench for preg_alloc_ctrl: a vector table for grant/refill
// behaviour, then hand-written sequences for the release FIFO and reset.
module tb_preg_alloc_ctrl;
    localparam int W = `PHYS_REG_IDX_SZ + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        alloc_req;
    logic [1:0]        alloc_gnt;
    logic [1:0][W-1:0] alloc_pr;
    logic [1:0]        release_en;
    logic [1:0][W-1:0] release_pr;
    logic              release_ready;
    logic              release_overflow;
    logic              fl_is_empty;
    logic [W-1:0]      fl_dequeue_pr;
    logic              fl_dequeue_en;
    logic              fl_enqueue_en;
    logic [W-1:0]      fl_enqueue_pr;
    logic [1:0]        prefetch_cnt;

    int n_cmp = 0;
    int n_err = 0;

    preg_alloc_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .alloc_req        (alloc_req),
        .alloc_gnt        (alloc_gnt),
        .alloc_pr         (alloc_pr),
        .release_en       (release_en),
        .release_pr       (release_pr),
        .release_ready    (release_ready),
        .release_overflow (release_overflow),
        .fl_is_empty      (fl_is_empty),
        .fl_dequeue_pr    (fl_dequeue_pr),
        .fl_dequeue_en    (fl_dequeue_en),
        .fl_enqueue_en    (fl_enqueue_en),
        .fl_enqueue_pr    (fl_enqueue_pr),
        .prefetch_cnt     (prefetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic [1:0]   req;
        logic         fle;
        logic [W-1:0] flpr;
        logic [1:0]   gnt;
        logic [W-1:0] pr0;
        logic [W-1:0] pr1;
        logic         deq;
        logic [1:0]   cnt;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] req, input logic fle, input logic [W-1:0] flpr,
                         input logic [1:0] ren, input logic [W-1:0] rp0, input logic [W-1:0] rp1);
        @(negedge clk);
        reset         = rst;
        alloc_req     = req;
        fl_is_empty   = fle;
        fl_dequeue_pr = flpr;
        release_en    = ren;
        release_pr[0] = rp0;
        release_pr[1] = rp1;
        #1;
    endtask

    // One release-FIFO cycle with no allocation traffic and an empty free list.
    task automatic fifo_step(input int idx, input logic [1:0] ren, input logic [W-1:0] rp0, input logic [W-1:0] rp1,
                             input logic e_en, input logic [W-1:0] e_pr, input logic e_rdy, input logic e_ovf);
        drive(1'b0, 2'b00, 1'b1, '0, ren, rp0, rp1);
        chk("fifo_enq_en", idx, 32'(fl_enqueue_en), 32'(e_en));
        if (e_en) chk("fifo_enq_pr", idx, 32'(fl_enqueue_pr), 32'(e_pr));
        chk("fifo_ready", idx, 32'(release_ready), 32'(e_rdy));
        chk("fifo_ovf", idx, 32'(release_overflow), 32'(e_ovf));
    endtask

    initial begin
        //             rst   req    fle   flpr  gnt    pr0   pr1   deq   cnt
        vt[0]  = '{1'b1, 2'b00, 1'b0, 6'd5, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0};
        vt[1]  = '{1'b0, 2'b00, 1'b0, 6'd5, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0};
        vt[2]  = '{1'b0, 2'b00, 1'b0, 6'd5, 2'b00, 6'd0, 6'd0, 1'b1, 2'd0};
        vt[3]  = '{1'b0, 2'b00, 1'b0, 6'd6, 2'b00, 6'd0, 6'd0, 1'b1, 2'd1};
        vt[4]  = '{1'b0, 2'b00, 1'b0, 6'd7, 2'b00, 6'd0, 6'd0, 1'b0, 2'd2};
        vt[5]  = '{1'b0, 2'b11, 1'b1, 6'd7, 2'b11, 6'd5, 6'd6, 1'b0, 2'd2};
        vt[6]  = '{1'b0, 2'b00, 1'b0, 6'd5, 2'b00, 6'd0, 6'd0, 1'b1, 2'd0};
        vt[7]  = '{1'b0, 2'b11, 1'b1, 6'd0, 2'b01, 6'd5, 6'd0, 1'b0, 2'd1};
        vt[8]  = '{1'b0, 2'b00, 1'b0, 6'd5, 2'b00, 6'd0, 6'd0, 1'b1, 2'd0};
        vt[9]  = '{1'b0, 2'b10, 1'b1, 6'd0, 2'b10, 6'd0, 6'd5, 1'b0, 2'd1};
        vt[10] = '{1'b0, 2'b11, 1'b1, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0};
        vt[11] = '{1'b0, 2'b11, 1'b1, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0};
        vt[12] = '{1'b0, 2'b11, 1'b1, 6'd3, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0};
        vt[13] = '{1'b0, 2'b11, 1'b1, 6'd3, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0};
        vt[14] = '{1'b0, 2'b11, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0};
        vt[15] = '{1'b0, 2'b00, 1'b0, 6'd8, 2'b00, 6'd0, 6'd0, 1'b1, 2'd0};
        vt[16] = '{1'b0, 2'b01, 1'b0, 6'd9, 2'b01, 6'd8, 6'd0, 1'b1, 2'd1};
        vt[17] = '{1'b0, 2'b00, 1'b0, 6'd10, 2'b00, 6'd0, 6'd0, 1'b1, 2'd1};
        vt[18] = '{1'b0, 2'b10, 1'b0, 6'd11, 2'b10, 6'd0, 6'd9, 1'b1, 2'd2};
        vt[19] = '{1'b0, 2'b11, 1'b1, 6'd0, 2'b11, 6'd10, 6'd11, 1'b0, 2'd2};
        vt[20] = '{1'b0, 2'b11, 1'b1, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0, 2'd0};

        reset = 1'b1; alloc_req = '0; fl_is_empty = 1'b1; fl_dequeue_pr = '0;
        release_en = '0; release_pr = '0;
        repeat (2) @(posedge clk);

        // Grant / refill table.
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].rst, vt[i].req, vt[i].fle, vt[i].flpr, 2'b00, '0, '0);
            chk("gnt", i, 32'(alloc_gnt), 32'(vt[i].gnt));
            if (vt[i].gnt[0]) chk("pr0", i, 32'(alloc_pr[0]), 32'(vt[i].pr0));
            if (vt[i].gnt[1]) chk("pr1", i, 32'(alloc_pr[1]), 32'(vt[i].pr1));
            chk("deq", i, 32'(fl_dequeue_en), 32'(vt[i].deq));
            chk("cnt", i, 32'(prefetch_cnt), 32'(vt[i].cnt));
            chk("enq_en", i, 32'(fl_enqueue_en), 32'd0);
            chk("ready", i, 32'(release_ready), 32'd1);
            chk("ovf", i, 32'(release_overflow), 32'd0);
        end

        // Release FIFO: ordered drain, fill to above two, drop on full, zero ignored.
        fifo_step(100, 2'b11, 6'd7,  6'd9,  1'b0, 6'd0,  1'b1, 1'b0);
        fifo_step(101, 2'b00, 6'd0,  6'd0,  1'b1, 6'd7,  1'b1, 1'b0);
        fifo_step(102, 2'b00, 6'd0,  6'd0,  1'b1, 6'd9,  1'b1, 1'b0);
        fifo_step(103, 2'b11, 6'd1,  6'd2,  1'b0, 6'd0,  1'b1, 1'b0);
        fifo_step(104, 2'b11, 6'd3,  6'd4,  1'b1, 6'd1,  1'b1, 1'b0);
        fifo_step(105, 2'b11, 6'd10, 6'd11, 1'b1, 6'd2,  1'b0, 1'b0);
        fifo_step(106, 2'b00, 6'd0,  6'd0,  1'b1, 6'd3,  1'b0, 1'b1);
        fifo_step(107, 2'b00, 6'd0,  6'd0,  1'b1, 6'd4,  1'b1, 1'b1);
        fifo_step(108, 2'b00, 6'd0,  6'd0,  1'b1, 6'd10, 1'b1, 1'b1);
        fifo_step(109, 2'b11, 6'd0,  6'd12, 1'b0, 6'd0,  1'b1, 1'b1);
        fifo_step(110, 2'b00, 6'd0,  6'd0,  1'b1, 6'd12, 1'b1, 1'b1);
        fifo_step(111, 2'b00, 6'd0,  6'd0,  1'b0, 6'd0,  1'b1, 1'b1);

        // Mid-operation reset with buffer {5,6} and FIFO holding {7}.
        drive(1'b0, 2'b00, 1'b0, 6'd5, 2'b00, '0, '0);
        chk("rst_seq_deq", 200, 32'(fl_dequeue_en), 32'd1);
        drive(1'b0, 2'b00, 1'b0, 6'd6, 2'b01, 6'd7, '0);
        chk("rst_seq_deq", 201, 32'(fl_dequeue_en), 32'd1);
        chk("rst_seq_cnt", 201, 32'(prefetch_cnt), 32'd1);
        drive(1'b1, 2'b00, 1'b0, 6'd7, 2'b00, '0, '0);
        chk("pre_rst_cnt", 202, 32'(prefetch_cnt), 32'd2);
        chk("pre_rst_enq_en", 202, 32'(fl_enqueue_en), 32'd1);
        chk("pre_rst_enq_pr", 202, 32'(fl_enqueue_pr), 32'd7);
        chk("pre_rst_ovf", 202, 32'(release_overflow), 32'd1);
        drive(1'b0, 2'b11, 1'b0, 6'd8, 2'b00, '0, '0);
        chk("post_rst_cnt", 203, 32'(prefetch_cnt), 32'd0);
        chk("post_rst_enq_en", 203, 32'(fl_enqueue_en), 32'd0);
        chk("post_rst_ovf", 203, 32'(release_overflow), 32'd0);
        chk("post_rst_gnt", 203, 32'(alloc_gnt), 32'd0);
        chk("post_rst_deq", 203, 32'(fl_dequeue_en), 32'd0);
        chk("post_rst_ready", 203, 32'(release_ready), 32'd1);
        drive(1'b0, 2'b11, 1'b0, 6'd8, 2'b00, '0, '0);
        chk("run_gnt", 204, 32'(alloc_gnt), 32'd0);
        chk("run_deq", 204, 32'(fl_dequeue_en), 32'd1);
        chk("run_enq_en", 204, 32'(fl_enqueue_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
